// File: rtl/oled_spi_pkg.sv
// Shared types for the OLED SPI master: FSM state encoding and the queued word format.
package oled_spi_pkg;

    typedef enum logic [2:0] {
        RES_HOLD = 3'd0,
        RES_WAIT = 3'd1,
        IDLE     = 3'd2,
        SHIFT    = 3'd3,
        GAP      = 3'd4
    } state_t;

    // Words travel MSB-aligned in a fixed-width container so any DATA_W up to this fits.
    localparam int SPI_MAX_W = 32;

    typedef struct packed {
        logic                 dc;
        logic [SPI_MAX_W-1:0] data;
    } spi_word_t;

    function automatic logic [SPI_MAX_W-1:0] msb_align(input logic [SPI_MAX_W-1:0] v, input int w);
        return v << (SPI_MAX_W - w);
    endfunction

endpackage

// File: rtl/spi_word_fifo.sv
// Small synchronous FIFO holding queued SPI words; extra pointer MSB distinguishes full from empty.
module spi_word_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wptr_q, wptr_d;
    logic [AW:0]      rptr_q, rptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             push_ok_s;
    logic             pop_ok_s;

    assign full      = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign empty     = (wptr_q == rptr_q);
    assign push_ok_s = push && !full;
    assign pop_ok_s  = pop && !empty;
    assign rdata     = mem_q[rptr_q[AW-1:0]];

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (push_ok_s) begin
            wptr_d = wptr_q + {{AW{1'b0}}, 1'b1};
        end else begin
            wptr_d = wptr_q;
        end
        if (pop_ok_s) begin
            rptr_d = rptr_q + {{AW{1'b0}}, 1'b1};
        end else begin
            rptr_d = rptr_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    // Storage needs no reset: contents are only read behind a valid pointer.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_q[wptr_q[AW-1:0]] <= wdata;
        end
    end

endmodule

// File: rtl/oled_spi_master.sv
// SPI mode-0 master for an SSD-class OLED: panel reset sequencing, queued D/C-tagged words, cs_n framing.
module oled_spi_master
    import oled_spi_pkg::*;
#(
    parameter int DATA_W          = 8,
    parameter int CLK_DIV         = 2,
    parameter int FIFO_DEPTH      = 4,
    parameter int RES_LOW_CYCLES  = 16,
    parameter int RES_WAIT_CYCLES = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_dc,
    output logic              in_ready,
    output logic              init_done,
    output logic              busy,
    output logic              spi_clk,
    output logic              mosi,
    output logic              dc,
    output logic              cs_n,
    output logic              res_n
);

    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BIT_W   = $clog2(DATA_W);
    localparam int RES_MAX = (RES_LOW_CYCLES > RES_WAIT_CYCLES) ? RES_LOW_CYCLES : RES_WAIT_CYCLES;
    localparam int RES_W   = (RES_MAX > 1) ? $clog2(RES_MAX) : 1;
    localparam int FW      = $bits(spi_word_t);

    localparam logic [DIV_W-1:0] DIV_LAST      = DIV_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST      = BIT_W'(DATA_W - 1);
    localparam logic [RES_W-1:0] RES_LOW_LAST  = RES_W'(RES_LOW_CYCLES - 1);
    localparam logic [RES_W-1:0] RES_WAIT_LAST = RES_W'(RES_WAIT_CYCLES - 1);

    state_t               state_q, state_d;
    logic [RES_W-1:0]     res_cnt_q, res_cnt_d;
    logic [DIV_W-1:0]     div_q, div_d;
    logic [BIT_W-1:0]     bit_q, bit_d;
    logic [SPI_MAX_W-1:0] shreg_q, shreg_d;
    logic                 spi_clk_q, spi_clk_d;
    logic                 mosi_q, mosi_d;
    logic                 dc_q, dc_d;
    logic                 cs_n_q, cs_n_d;
    logic                 res_n_q, res_n_d;
    logic                 init_done_q, init_done_d;

    spi_word_t            wr_word_s;
    spi_word_t            rd_word_s;
    logic                 push_s;
    logic                 pop_s;
    logic                 full_s;
    logic                 empty_s;

    assign wr_word_s = '{dc: in_dc, data: msb_align(SPI_MAX_W'(in_data), DATA_W)};
    assign in_ready  = init_done_q & ~full_s;
    assign push_s    = in_valid & in_ready;
    assign busy      = ~empty_s | (state_q != IDLE);

    assign spi_clk   = spi_clk_q;
    assign mosi      = mosi_q;
    assign dc        = dc_q;
    assign cs_n      = cs_n_q;
    assign res_n     = res_n_q;
    assign init_done = init_done_q;

    spi_word_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (FW)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_s),
        .wdata (wr_word_s),
        .pop   (pop_s),
        .rdata (rd_word_s),
        .full  (full_s),
        .empty (empty_s)
    );

    always_comb begin
        state_d     = state_q;
        res_cnt_d   = res_cnt_q;
        div_d       = div_q;
        bit_d       = bit_q;
        shreg_d     = shreg_q;
        spi_clk_d   = spi_clk_q;
        mosi_d      = mosi_q;
        dc_d        = dc_q;
        cs_n_d      = cs_n_q;
        res_n_d     = res_n_q;
        init_done_d = init_done_q;
        pop_s       = 1'b0;
        case (state_q)
            RES_HOLD: begin
                if (res_cnt_q == RES_LOW_LAST) begin
                    res_n_d   = 1'b1;
                    res_cnt_d = '0;
                    state_d   = RES_WAIT;
                end else begin
                    res_cnt_d = res_cnt_q + RES_W'(1);
                end
            end
            RES_WAIT: begin
                if (res_cnt_q == RES_WAIT_LAST) begin
                    init_done_d = 1'b1;
                    state_d     = IDLE;
                end else begin
                    res_cnt_d = res_cnt_q + RES_W'(1);
                end
            end
            IDLE: begin
                if (!empty_s) begin
                    pop_s   = 1'b1;
                    cs_n_d  = 1'b0;
                    dc_d    = rd_word_s.dc;
                    shreg_d = rd_word_s.data;
                    mosi_d  = rd_word_s.data[SPI_MAX_W-1];
                    bit_d   = '0;
                    div_d   = '0;
                    state_d = SHIFT;
                end else begin
                    state_d = IDLE;
                end
            end
            SHIFT: begin
                if (div_q == DIV_LAST) begin
                    div_d = '0;
                    if (!spi_clk_q) begin
                        spi_clk_d = 1'b1;
                    end else begin
                        spi_clk_d = 1'b0;
                        if (bit_q == BIT_LAST) begin
                            // Final falling edge: chain straight into the next word to keep the pitch exact.
                            if (!empty_s) begin
                                pop_s   = 1'b1;
                                dc_d    = rd_word_s.dc;
                                shreg_d = rd_word_s.data;
                                mosi_d  = rd_word_s.data[SPI_MAX_W-1];
                                bit_d   = '0;
                            end else begin
                                state_d = GAP;
                            end
                        end else begin
                            bit_d   = bit_q + BIT_W'(1);
                            shreg_d = shreg_q << 1;
                            mosi_d  = shreg_q[SPI_MAX_W-2];
                        end
                    end
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end
            GAP: begin
                if (div_q == DIV_LAST) begin
                    div_d   = '0;
                    cs_n_d  = 1'b1;
                    mosi_d  = 1'b0;
                    state_d = IDLE;
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end
            default: begin
                state_d = RES_HOLD;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= RES_HOLD;
            res_cnt_q   <= '0;
            div_q       <= '0;
            bit_q       <= '0;
            shreg_q     <= '0;
            spi_clk_q   <= 1'b0;
            mosi_q      <= 1'b0;
            dc_q        <= 1'b0;
            cs_n_q      <= 1'b1;
            res_n_q     <= 1'b0;
            init_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            res_cnt_q   <= res_cnt_d;
            div_q       <= div_d;
            bit_q       <= bit_d;
            shreg_q     <= shreg_d;
            spi_clk_q   <= spi_clk_d;
            mosi_q      <= mosi_d;
            dc_q        <= dc_d;
            cs_n_q      <= cs_n_d;
            res_n_q     <= res_n_d;
            init_done_q <= init_done_d;
        end
    end

endmodule

// File: tb/tb_oled_spi_master.sv
// Scoreboard bench for oled_spi_master: default 8-bit instance plus a 16-bit / CLK_DIV=1 / depth-2 instance.
module tb_oled_spi_master;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_dc = 1'b0;
    logic        in_ready, init_done, busy, spi_clk, mosi, dc, cs_n, res_n;

    logic        w_in_valid = 1'b0;
    logic [15:0] w_in_data = 16'h0000;
    logic        w_in_dc = 1'b0;
    logic        w_in_ready, w_init_done, w_busy, w_spi_clk, w_mosi, w_dc, w_cs_n, w_res_n;

    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;
    int acc_cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    oled_spi_master u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_dc(in_dc),
        .in_ready(in_ready), .init_done(init_done), .busy(busy), .spi_clk(spi_clk),
        .mosi(mosi), .dc(dc), .cs_n(cs_n), .res_n(res_n)
    );

    oled_spi_master #(.DATA_W(16), .CLK_DIV(1), .FIFO_DEPTH(2)) u_wide (
        .clk(clk), .rst(rst), .in_valid(w_in_valid), .in_data(w_in_data), .in_dc(w_in_dc),
        .in_ready(w_in_ready), .init_done(w_init_done), .busy(w_busy), .spi_clk(w_spi_clk),
        .mosi(w_mosi), .dc(w_dc), .cs_n(w_cs_n), .res_n(w_res_n)
    );

    // Scoreboard queues and monitor state
    logic [8:0]  exp_q[$];
    logic [8:0]  obs_q[$];
    logic [16:0] w_exp_q[$];
    logic [16:0] w_obs_q[$];
    int rise_q[$];
    int cs_fall_q[$];
    int cs_rise_q[$];
    int w_rise_q[$];
    int mon_bits = 0;
    int mon_viol = 0;
    int w_bits = 0;
    logic [7:0]  mon_sh = 8'h00;
    logic [15:0] w_sh = 16'h0000;
    logic mon_dc = 1'b0, p_clk = 1'b0, p_mosi = 1'b0, p_dc = 1'b0, p_cs = 1'b1, wp_clk = 1'b0;

    // Decode words on rising spi_clk; flag any pin movement while spi_clk is high
    always @(negedge clk) begin
        if (rst) begin
            mon_bits = 0;
        end else begin
            if (spi_clk && !p_clk) begin
                if (mon_bits == 0) mon_dc = dc;
                if (dc !== mon_dc || cs_n !== 1'b0) mon_viol++;
                rise_q.push_back(cyc);
                mon_sh = {mon_sh[6:0], mosi};
                mon_bits++;
                if (mon_bits == 8) begin
                    obs_q.push_back({mon_dc, mon_sh});
                    mon_bits = 0;
                end
            end
            if (spi_clk && (mosi !== p_mosi || dc !== p_dc || cs_n !== p_cs)) mon_viol++;
            if (!cs_n && p_cs) cs_fall_q.push_back(cyc);
            if (cs_n && !p_cs) begin
                cs_rise_q.push_back(cyc);
                mon_bits = 0;
            end
        end
        p_clk = spi_clk; p_mosi = mosi; p_dc = dc; p_cs = cs_n;
    end

    // Decode the wide instance's words
    always @(negedge clk) begin
        if (rst) begin
            w_bits = 0;
        end else if (w_spi_clk && !wp_clk) begin
            w_rise_q.push_back(cyc);
            w_sh = {w_sh[14:0], w_mosi};
            w_bits++;
            if (w_bits == 16) begin
                w_obs_q.push_back({w_dc, w_sh});
                w_bits = 0;
            end
        end
        wp_clk = w_spi_clk;
    end

    task automatic send(input logic d, input logic [7:0] v);
        int guard;
        guard = 0;
        in_valid = 1'b1; in_dc = d; in_data = v;
        while (in_ready !== 1'b1 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        n_checks++;
        if (guard >= 200) begin
            n_fail++;
            $display("FAIL push_timeout: in_ready=%b, required 1", in_ready);
        end else begin
            exp_q.push_back({d, v});
        end
        @(negedge clk);
        acc_cyc = cyc;
        in_valid = 1'b0;
    endtask

    task automatic send_w(input logic d, input logic [15:0] v);
        int guard;
        guard = 0;
        w_in_valid = 1'b1; w_in_dc = d; w_in_data = v;
        while (w_in_ready !== 1'b1 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        n_checks++;
        if (guard >= 200) begin
            n_fail++;
            $display("FAIL wide_push_timeout: in_ready=%b, required 1", w_in_ready);
        end else begin
            w_exp_q.push_back({d, v});
        end
        @(negedge clk);
        acc_cyc = cyc;
        w_in_valid = 1'b0;
    endtask

    task automatic clear_mon();
        rise_q.delete(); cs_fall_q.delete(); cs_rise_q.delete(); obs_q.delete();
        mon_viol = 0;
    endtask

    task automatic test_reset();
        logic [2:0] want;
        @(negedge clk);
        n_checks++;
        if ({spi_clk, mosi, dc, cs_n, res_n, in_ready, init_done, busy} !== 8'b0001_0001) begin
            n_fail++;
            $display("FAIL reset_values: got %b required %b",
                     {spi_clk, mosi, dc, cs_n, res_n, in_ready, init_done, busy}, 8'b0001_0001);
        end
        n_checks++;
        if ({w_res_n, w_cs_n, w_busy} !== 3'b011) begin
            n_fail++;
            $display("FAIL wide_reset_values: got %b required %b", {w_res_n, w_cs_n, w_busy}, 3'b011);
        end
        rst = 1'b0;
        for (int k = 1; k <= 34; k++) begin
            @(negedge clk);
            want = {(k >= 16) ? 1'b1 : 1'b0, (k >= 32) ? 1'b1 : 1'b0, (k >= 32) ? 1'b1 : 1'b0};
            n_checks++;
            if ({res_n, init_done, in_ready} !== want) begin
                n_fail++;
                $display("FAIL reset_seq cycle %0d: res_n/init_done/in_ready got %b required %b",
                         k, {res_n, init_done, in_ready}, want);
            end
        end
    endtask

    task automatic test_single();
        logic [8:0] got, want;
        int a;
        clear_mon();
        send(1'b0, 8'hAF);
        a = acc_cyc;
        for (int t = 0; t < 200 && cs_rise_q.size() < 1; t++) @(posedge clk);
        n_checks++;
        if (obs_q.size() != 1 || exp_q.size() != 1) begin
            n_fail++;
            $display("FAIL single_count: observed %0d words, required 1", obs_q.size());
        end else begin
            got = obs_q.pop_front(); want = exp_q.pop_front();
            if (got !== want) begin
                n_fail++;
                $display("FAIL single_word: got %h required %h", got, want);
            end
        end
        n_checks++;
        if (cs_fall_q.size() != 1 || cs_fall_q[0] != a + 1) begin
            n_fail++;
            $display("FAIL single_cs_fall: got %0d falls, first at %0d, required 1 at %0d",
                     cs_fall_q.size(), (cs_fall_q.size() > 0) ? cs_fall_q[0] : -1, a + 1);
        end
        n_checks++;
        if (rise_q.size() != 8 || rise_q[0] != a + 3) begin
            n_fail++;
            $display("FAIL single_rises: got %0d rises, first at %0d, required 8 from %0d",
                     rise_q.size(), (rise_q.size() > 0) ? rise_q[0] : -1, a + 3);
        end else begin
            for (int i = 1; i < 8; i++) begin
                n_checks++;
                if (rise_q[i] - rise_q[i-1] != 4) begin
                    n_fail++;
                    $display("FAIL single_bit_period %0d: got %0d required 4", i, rise_q[i] - rise_q[i-1]);
                end
            end
            n_checks++;
            if (cs_rise_q.size() != 1 || cs_rise_q[0] != rise_q[7] + 4) begin
                n_fail++;
                $display("FAIL single_cs_rise: got %0d required %0d",
                         (cs_rise_q.size() > 0) ? cs_rise_q[0] : -1, rise_q[7] + 4);
            end
        end
        @(negedge clk);
        n_checks++;
        if ({busy, cs_n, mosi, mon_viol != 0} !== 4'b0100) begin
            n_fail++;
            $display("FAIL single_end: busy/cs_n/mosi/violation got %b required 0100",
                     {busy, cs_n, mosi, mon_viol != 0});
        end
    endtask

    task automatic test_back_to_back();
        logic [8:0] got, want;
        clear_mon();
        send(1'b0, 8'h81);
        send(1'b1, 8'h7F);
        send(1'b1, 8'h00);
        for (int t = 0; t < 300 && cs_rise_q.size() < 1; t++) @(posedge clk);
        n_checks++;
        if (obs_q.size() != 3 || exp_q.size() != 3) begin
            n_fail++;
            $display("FAIL b2b_count: observed %0d words, required 3", obs_q.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                got = obs_q.pop_front(); want = exp_q.pop_front();
                n_checks++;
                if (got !== want) begin
                    n_fail++;
                    $display("FAIL b2b_word %0d: got %h required %h", i, got, want);
                end
            end
        end
        n_checks++;
        if (cs_fall_q.size() != 1 || cs_rise_q.size() != 1) begin
            n_fail++;
            $display("FAIL b2b_frame: cs_n falls %0d rises %0d, required 1 and 1",
                     cs_fall_q.size(), cs_rise_q.size());
        end
        n_checks++;
        if (rise_q.size() != 24) begin
            n_fail++;
            $display("FAIL b2b_rises: got %0d required 24", rise_q.size());
        end else begin
            n_checks++;
            if (rise_q[8] - rise_q[0] != 32 || rise_q[16] - rise_q[8] != 32) begin
                n_fail++;
                $display("FAIL b2b_pitch: got %0d and %0d required 32",
                         rise_q[8] - rise_q[0], rise_q[16] - rise_q[8]);
            end
        end
        n_checks++;
        if (mon_viol != 0) begin
            n_fail++;
            $display("FAIL b2b_stability: %0d pin changes while spi_clk high, required 0", mon_viol);
        end
    endtask

    task automatic test_fifo_full();
        logic [8:0] got, want;
        int a;
        clear_mon();
        send(1'b0, 8'h11);
        a = acc_cyc;
        send(1'b1, 8'h22);
        send(1'b1, 8'h33);
        send(1'b0, 8'h44);
        send(1'b1, 8'h55);
        n_checks++;
        if (in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL full_ready: in_ready got %b required 0", in_ready);
        end
        send(1'b0, 8'h66);
        n_checks++;
        if (acc_cyc != a + 34) begin
            n_fail++;
            $display("FAIL full_sixth_accept: accepted at %0d required %0d", acc_cyc, a + 34);
        end
        for (int t = 0; t < 400 && cs_rise_q.size() < 1; t++) @(posedge clk);
        n_checks++;
        if (obs_q.size() != 6 || exp_q.size() != 6) begin
            n_fail++;
            $display("FAIL full_count: observed %0d words expected-queue %0d, required 6",
                     obs_q.size(), exp_q.size());
        end else begin
            for (int i = 0; i < 6; i++) begin
                got = obs_q.pop_front(); want = exp_q.pop_front();
                n_checks++;
                if (got !== want) begin
                    n_fail++;
                    $display("FAIL full_order %0d: got %h required %h", i, got, want);
                end
            end
        end
        n_checks++;
        if (cs_fall_q.size() != 1 || mon_viol != 0) begin
            n_fail++;
            $display("FAIL full_frame: cs_n falls %0d violations %0d, required 1 and 0",
                     cs_fall_q.size(), mon_viol);
        end
    endtask

    task automatic test_abort();
        logic [1:0] want;
        clear_mon();
        send(1'b0, 8'hC3);
        send(1'b1, 8'h3C);
        for (int t = 0; t < 100 && rise_q.size() < 3; t++) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        n_checks++;
        if ({cs_n, spi_clk, res_n, in_ready, init_done} !== 5'b10000) begin
            n_fail++;
            $display("FAIL abort_same_cycle: cs_n/spi_clk/res_n/in_ready/init_done got %b required 10000",
                     {cs_n, spi_clk, res_n, in_ready, init_done});
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        clear_mon();
        for (int k = 1; k <= 32; k++) begin
            @(negedge clk);
            want = {(k >= 16) ? 1'b1 : 1'b0, (k >= 32) ? 1'b1 : 1'b0};
            n_checks++;
            if ({res_n, init_done} !== want) begin
                n_fail++;
                $display("FAIL abort_reseq cycle %0d: res_n/init_done got %b required %b",
                         k, {res_n, init_done}, want);
            end
        end
        repeat (40) @(negedge clk);
        n_checks++;
        if (cs_fall_q.size() != 0 || obs_q.size() != 0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_flush: cs_n falls %0d words %0d busy %b, required 0 0 0",
                     cs_fall_q.size(), obs_q.size(), busy);
        end
    endtask

    task automatic test_sweep();
        logic [16:0] got, want;
        int a;
        for (int t = 0; t < 100 && w_init_done !== 1'b1; t++) @(negedge clk);
        w_rise_q.delete(); w_obs_q.delete();
        send_w(1'b1, 16'hBEEF);
        a = acc_cyc;
        for (int t = 0; t < 200 && w_obs_q.size() < 1; t++) @(posedge clk);
        repeat (4) @(negedge clk);
        n_checks++;
        if (w_obs_q.size() != 1 || w_exp_q.size() != 1) begin
            n_fail++;
            $display("FAIL sweep_count: observed %0d words, required 1", w_obs_q.size());
        end else begin
            got = w_obs_q.pop_front(); want = w_exp_q.pop_front();
            if (got !== want) begin
                n_fail++;
                $display("FAIL sweep_word: got %h required %h", got, want);
            end
        end
        n_checks++;
        if (w_rise_q.size() != 16 || w_rise_q[0] != a + 2) begin
            n_fail++;
            $display("FAIL sweep_rises: got %0d rises first at %0d, required 16 from %0d",
                     w_rise_q.size(), (w_rise_q.size() > 0) ? w_rise_q[0] : -1, a + 2);
        end else begin
            for (int i = 1; i < 16; i++) begin
                n_checks++;
                if (w_rise_q[i] - w_rise_q[i-1] != 2) begin
                    n_fail++;
                    $display("FAIL sweep_bit_period %0d: got %0d required 2", i, w_rise_q[i] - w_rise_q[i-1]);
                end
            end
        end
        n_checks++;
        if ({w_cs_n, w_busy} !== 2'b10) begin
            n_fail++;
            $display("FAIL sweep_end: cs_n/busy got %b required 10", {w_cs_n, w_busy});
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_fifo_full();
        test_abort();
        test_sweep();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
